mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one multi-cycle main-memory port between the instruction-fetch read requester and the MEM-stage data read/write requester.
- Generates the instruction_mem_busywait and data_mem_busywait signals. These are ORed into the PC-update stall, so the pipeline advances only when both are low.
- Holds each completed result until the pipeline actually advances, so a requester already served is not re-accessed while the other requester is still stalling.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- DATA_FIRST, 1, tie-break when both requesters are pending in IDLE: 1 grants data first, 0 grants instruction first.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_read  in  1  fetch read request; held until instruction_mem_busywait is low at a CLK edge.
- i_address  in  ADDR_W  fetch address (PC).
- i_readdata  out  DATA_W  fetched instruction.
- instruction_mem_busywait  out  1  fetch stall.
- d_read  in  1  load request.
- d_write  in  1  store request; d_read and d_write are never both high.
- d_address  in  ADDR_W  load/store address.
- d_writedata  in  DATA_W  store data.
- d_readdata  out  DATA_W  load data.
- data_mem_busywait  out  1  data stall.
- mem_req  out  1  main-memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W  registered at grant.
- mem_wdata  out  DATA_W  registered at grant.
- mem_rdata  in  DATA_W  valid in the cycle mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (RESET low, asynchronous): state = IDLE; mem_req, mem_we = 0; mem_addr, mem_wdata, i_readdata, d_readdata = 0; i_valid, d_valid = 0.
  - Both busywaits then follow their combinational equations.
  - Reset mid-transaction abandons it; an mem_ack arriving in IDLE is ignored.
- Combinational outputs:
  - instruction_mem_busywait = i_read & ~i_valid
  - data_mem_busywait = (d_read | d_write) & ~d_valid
  - advance = ~instruction_mem_busywait & ~data_mem_busywait
- State IDLE:
  - i_pend = instruction_mem_busywait; d_pend = data_mem_busywait.
  - If only one is pending, grant it. If both are pending, grant per DATA_FIRST.
  - On grant, register mem_addr (and, for data, mem_we = d_write and mem_wdata = d_writedata), set mem_req = 1, and go to BUS_I or BUS_D.
  - No grant in the same cycle as a completion.
- State BUS_I / BUS_D:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Requester inputs changing during the transaction are ignored.
  - On the edge with mem_ack = 1: mem_req = 0, mem_we = 0; the granted requester's valid flag is set; go to IDLE.
  - On that same edge, latch i_readdata (BUS_I), or d_readdata for a read (BUS_D). A write leaves d_readdata unchanged.
- Valid flags:
  - On any edge where advance = 1, i_valid and d_valid both clear.
  - If a valid flag is both set by mem_ack and cleared by advance on the same edge, set wins. This cannot happen for the granted side, because its busywait is high.
- Latency:
  - Request high in cycle 0 (IDLE) gives mem_req high from cycle 1.
  - With ack after N cycles of mem_req (N ≥ 1), the requester's busywait is low in cycle N+1.
  - Minimum busywait duration is 2 cycles. When both requesters are pending, the second waits an additional N+1 cycles.
- Idle requester: a requester with no request never stalls and never takes a grant.
- Readdata registers hold their value until overwritten.

Decomposition:
- Shared package: ARB_IDLE, ARB_BUS_I, ARB_BUS_D state encoding; default ADDR_W/DATA_W constants reused by the fetch and data-memory blocks.
- No sub-module: a single FSM with its datapath registers is natural.

Test Plan:
- Fetch only: i_read = 1, i_address = 0x00000010, memory acks after 3 cycles with 0x00A00093. Required: mem_addr = 0x10, mem_we = 0; busywait high 4 cycles then low 1 cycle; i_readdata = 0x00A00093.
- Simultaneous, DATA_FIRST = 1: i_read at 0x14 and d_write at 0x100 with data 0xDEADBEEF. Required: first transaction is mem_we = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF; fetch transaction next; data_mem_busywait stays low after its ack while fetch is still stalled; no second write to 0x100.
- Simultaneous, DATA_FIRST = 0, d_read at 0x200 returning 0x12345678. Required: fetch is granted first; d_readdata = 0x12345678 afterwards.
- Back-to-back stores to 0x100 (0x1, then 0x2) with one advance between. Required: two mem write transactions, in order.
- RESET pulled low while in BUS_D, with a stale mem_ack one cycle after release. Required: all outputs at reset values, state = IDLE, stale ack ignored, new request serviced normally.
- No requests for 10 cycles. Required: mem_req = 0 and both busywaits = 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: state encoding and default bus widths
// reused by the fetch and data-memory blocks.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_BUS_I = 2'd1;
  localparam arb_state_t ARB_BUS_D = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and the MEM-stage data port,
// holding each completed result until the pipeline advances.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              instruction_mem_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              data_mem_busywait,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        state_q, state_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic i_busy, d_busy, advance;
  logic grant_d, grant_i;

  assign i_busy  = i_read & ~i_valid_q;
  assign d_busy  = (d_read | d_write) & ~d_valid_q;
  assign advance = ~i_busy & ~d_busy;

  // Busywaits double as the pending flags, so an already-served side never re-arbitrates.
  assign grant_d = d_busy & (DATA_FIRST | ~i_busy);
  assign grant_i = i_busy & ~grant_d;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = advance ? 1'b0 : i_valid_q;
    d_valid_d   = advance ? 1'b0 : d_valid_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d     = ARB_BUS_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_address;
          mem_wdata_d = d_writedata;
        end else if (grant_i) begin
          state_d    = ARB_BUS_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_address;
        end
      end
      ARB_BUS_I: begin
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          i_valid_d = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      ARB_BUS_D: begin
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ARB_IDLE;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign instruction_mem_busywait = i_busy;
  assign data_mem_busywait        = d_busy;
  assign mem_req                  = mem_req_q;
  assign mem_we                   = mem_we_q;
  assign mem_addr                 = mem_addr_q;
  assign mem_wdata                = mem_wdata_q;
  assign i_readdata               = i_rdata_q;
  assign d_readdata               = d_rdata_q;

endmodule
